// File: rtl/sprite_fetch.sv
// sprite_fetch: raster-driven sprite ROM reader with a latency-matched hit tag.
// Optional build macro TRANSPARENT_KEY_EN masks KEY-coloured pixels.
module sprite_fetch #(
  parameter int unsigned SPR_W   = 160,
  parameter int unsigned SPR_H   = 200,
  parameter int unsigned ROM_LAT = 1,
  parameter logic [11:0] KEY     = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic [9:0]  col,
  input  logic [8:0]  row,
  input  logic [9:0]  sprite_x,
  input  logic [8:0]  sprite_y,
  input  logic        show,
  output logic [14:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pixel,
  output logic        pixel_valid
);

  localparam logic [10:0] W11 = 11'(SPR_W);
  localparam logic [10:0] H11 = 11'(SPR_H);
  localparam logic [14:0] W15 = 15'(SPR_W);

  logic [9:0]       x_l_q, x_l_d;
  logic [8:0]       y_l_q, y_l_d;
  logic             show_l_q, show_l_d;
  logic [14:0]      line_base_q, line_base_d;
  logic             row_seen_q, row_seen_d;
  logic [14:0]      addr_q, addr_d;
  logic [ROM_LAT:0] tag_q, tag_d;
  logic [11:0]      pix_q, pix_d;
  logic             valid_q, valid_d;

  logic [10:0] row11, y11, col11, x11;
  logic        row_hit, in_spr, hit, opaque;
  logic [9:0]  offs;

  // Hit test with 11-bit sums so sprites past the screen edge never wrap.
  always_comb begin
    row11   = {2'b00, row};
    y11     = {2'b00, y_l_q};
    col11   = {1'b0, col};
    x11     = {1'b0, x_l_q};
    row_hit = show_l_q && (row11 >= y11) && (row11 < y11 + H11);
    in_spr  = row_hit && (col11 >= x11) && (col11 < x11 + W11);
    offs    = col - x_l_q;
  end

  // Frame latch, line base, address and tag next-state; frame_start wins.
  always_comb begin
    x_l_d       = x_l_q;
    y_l_d       = y_l_q;
    show_l_d    = show_l_q;
    line_base_d = line_base_q;
    row_seen_d  = row_seen_q;
    addr_d      = addr_q;
    hit         = 1'b0;
    if (frame_start) begin
      x_l_d       = sprite_x;
      y_l_d       = sprite_y;
      show_l_d    = show;
      line_base_d = '0;
      row_seen_d  = 1'b0;
    end else begin
      hit = pix_en && in_spr;
      if (hit) addr_d = line_base_q + {5'b00000, offs};
      if (pix_en) row_seen_d = row_hit;
      if (line_end && (pix_en ? row_hit : row_seen_q))
        line_base_d = line_base_q + W15;
    end
    tag_d = {tag_q[ROM_LAT-1:0], hit};
  end

  // Output stage: tag delayed ROM_LAT+1 cycles lines up with rom_data.
  always_comb begin
    opaque = tag_q[ROM_LAT];
`ifdef TRANSPARENT_KEY_EN
    opaque = tag_q[ROM_LAT] && (rom_data != KEY);
`endif
    valid_d = opaque;
    pix_d   = opaque ? rom_data : 12'h000;
  end

`ifndef TRANSPARENT_KEY_EN
  logic unused_key;
  assign unused_key = ^KEY;
`endif

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l_q       <= '0;
      y_l_q       <= '0;
      show_l_q    <= 1'b0;
      line_base_q <= '0;
      row_seen_q  <= 1'b0;
      addr_q      <= '0;
      tag_q       <= '0;
      pix_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      x_l_q       <= x_l_d;
      y_l_q       <= y_l_d;
      show_l_q    <= show_l_d;
      line_base_q <= line_base_d;
      row_seen_q  <= row_seen_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      pix_q       <= pix_d;
      valid_q     <= valid_d;
    end
  end

  assign rom_addr    = addr_q;
  assign pixel       = pix_q;
  assign pixel_valid = valid_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: random raster frames against a coordinate-level model.
// Expected addresses/pixels are queued at issue and checked by a monitor.
module tb_sprite_fetch;
  localparam int W   = 160;
  localparam int H   = 200;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_end = 1'b0;
  logic        show = 1'b0;
  logic [9:0]  col = '0;
  logic [9:0]  sprite_x = '0;
  logic [8:0]  row = '0;
  logic [8:0]  sprite_y = '0;
  logic [14:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] pixel;
  logic        pixel_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { int due; logic [11:0] px; } pexp_t;
  typedef struct { int due; logic [14:0] a; } aexp_t;
  pexp_t pq[$];
  aexp_t aq[$];

  int fx = 0;
  int fy = 0;
  bit fshow = 1'b0;

  sprite_fetch #(.SPR_W(W), .SPR_H(H), .ROM_LAT(LAT), .KEY(12'hFFF)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .frame_start(frame_start), .line_end(line_end),
    .col(col), .row(row), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .show(show), .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rom_fn(input int a);
    if (a % 23 == 7) return 12'hFFF;
    return 12'((a * 7 + (a >> 9)) % 4095);
  endfunction

  logic [11:0] rd_q [LAT];
  always @(posedge clk) begin
    rd_q[0] <= rom_fn(int'(rom_addr));
    for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign rom_data = rd_q[LAT-1];

  always @(negedge clk) begin
    if (rst_n) begin
      while (aq.size() > 0 && aq[0].due < cyc) begin
        bad++;
        $display("FAIL addr_skipped due=%0d now=%0d", aq[0].due, cyc);
        void'(aq.pop_front());
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        total++;
        if (rom_addr !== aq[0].a) begin
          bad++;
          $display("FAIL rom_addr cyc=%0d got=%0d want=%0d",
                   cyc, rom_addr, aq[0].a);
        end
        void'(aq.pop_front());
      end
      total++;
      if (pixel_valid) begin
        if (pq.size() == 0) begin
          bad++;
          $display("FAIL spurious_valid cyc=%0d got=%h want=none", cyc, pixel);
        end else begin
          if (pq[0].due != cyc || pixel !== pq[0].px) begin
            bad++;
            $display("FAIL pixel cyc=%0d got=%h want=%h due=%0d",
                     cyc, pixel, pq[0].px, pq[0].due);
          end
          void'(pq.pop_front());
        end
      end else begin
        if (pixel !== 12'h000) begin
          bad++;
          $display("FAIL idle_pixel cyc=%0d got=%h want=000", cyc, pixel);
        end else if (pq.size() > 0 && pq[0].due <= cyc) begin
          bad++;
          $display("FAIL missing_valid cyc=%0d got=0 want=%h", cyc, pq[0].px);
          void'(pq.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit pe, input bit le, input int c, input int r);
    int a;
    logic [11:0] px;
    @(negedge clk);
    pix_en      = pe;
    frame_start = 1'b0;
    line_end    = le;
    col         = 10'(c);
    row         = 9'(r);
    sprite_x    = 10'($urandom_range(0, 639));
    sprite_y    = 9'($urandom_range(0, 479));
    show        = 1'($urandom);
    if (pe && fshow && r >= fy && r < fy + H && c >= fx && c < fx + W) begin
      a = (r - fy) * W + (c - fx);
      aq.push_back('{due: cyc + 1, a: 15'(a)});
      px = rom_fn(a);
`ifdef TRANSPARENT_KEY_EN
      if (px != 12'hFFF)
`endif
      pq.push_back('{due: cyc + 2 + LAT, px: px});
    end
  endtask

  task automatic start_frame(input int x, input int y, input bit sh);
    int reps;
    reps = 1 + ($urandom % 2);
    for (int i = 0; i < reps; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      line_end    = 1'b1;
      pix_en      = 1'b1;
      col         = 10'(x);
      row         = 9'(y);
      sprite_x    = 10'(x);
      sprite_y    = 9'(y);
      show        = sh;
    end
    fx = x;
    fy = y;
    fshow = sh;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b0;
    line_end = 1'b0;
    #2;
    rst_n = 1'b0;
    pq.delete();
    aq.delete();
    fshow = 1'b0;
    #1;
    total += 3;
    if (pixel_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b want=0", pixel_valid);
    end
    if (rom_addr !== 15'd0) begin
      bad++;
      $display("FAIL rst_addr got=%0d want=0", rom_addr);
    end
    if (pixel !== 12'h000) begin
      bad++;
      $display("FAIL rst_pixel got=%h want=000", pixel);
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic int pick_col(input int k);
    int c;
    case ($urandom % 6)
      0: c = fx - 1;
      1: c = fx;
      2: c = fx + W - 1;
      3: c = fx + W;
      4: c = fx + int'($urandom % W);
      default: c = int'($urandom_range(0, 639));
    endcase
    if (k == 0 && ($urandom % 2) == 0) c = fx;
    if (c < 0 || c > 639) c = int'($urandom_range(0, 639));
    return c;
  endfunction

  task automatic run_frame(input int x, input int y, input bit sh,
                           input int rst_row);
    bit pe;
    start_frame(x, y, sh);
    for (int r = 0; r < 480; r++) begin
      if (r == rst_row) do_reset();
      for (int k = 0; k < 5; k++) begin
        pe = (k == 0) || (($urandom % 5) != 0);
        drive(pe, 1'b0, pick_col(k), r);
      end
      drive(($urandom % 4) == 0, 1'b1, pick_col(1), r);
    end
    drive(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    total += 3;
    if (pixel_valid !== 1'b0) begin
      bad++;
      $display("FAIL init_valid got=%b want=0", pixel_valid);
    end
    if (rom_addr !== 15'd0) begin
      bad++;
      $display("FAIL init_addr got=%0d want=0", rom_addr);
    end
    if (pixel !== 12'h000) begin
      bad++;
      $display("FAIL init_pixel got=%h want=000", pixel);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++)
      drive(1'b1, 1'b0, 100 + i, 50);
    run_frame(100, 50, 1'b1, -1);
    run_frame(600, int'($urandom_range(0, 250)), 1'b1, -1);
    run_frame(int'($urandom_range(0, 639)), 400, 1'b1, -1);
    run_frame(int'($urandom_range(0, 400)), 30, 1'b0, -1);
    run_frame(100, 50, 1'b1, 120);
    run_frame(int'($urandom_range(0, 639)),
              int'($urandom_range(0, 479)), 1'b1, -1);
    run_frame(560, 330, 1'b1, -1);
    repeat (10) drive(1'b0, 1'b0, 0, 0);
    total++;
    if (pq.size() != 0 || aq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", pq.size(), aq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Raster-driven reader for the game's sprite image ROMs (12-bit RGB444 words, 15-bit word address, 1-cycle synchronous read). Sits between the VGA timing generator and one image ROM instance. It turns the current pixel coordinate plus a sprite position into ROM addresses, tracks the ROM read latency, and delivers aligned sprite pixels with a valid flag to the display mux.

## Interface
Parameters:
- SPR_W, 160, sprite width in pixels
- SPR_H, 200, sprite height in pixels; SPR_W*SPR_H ≤ 32768
- ROM_LAT, 1, ROM read latency in clk cycles (1 or 2)
- KEY, 12'hFFF, transparent colour (used only with the configuration macro)

Ports:
- clk  in  1  system clock; ROM shares it
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe; col/row are sampled when high
- frame_start  in  1  one-cycle pulse in vertical blanking before row 0
- line_end  in  1  one-cycle pulse in horizontal blanking after each row
- col  in  10  current pixel column, 0..639
- row  in  9  current pixel row, 0..479
- sprite_x  in  10  sprite left column, sampled at frame_start
- sprite_y  in  9  sprite top row, sampled at frame_start
- show  in  1  sprite enable, sampled at frame_start
- rom_addr  out  15  ROM word address (registered)
- rom_data  in  12  ROM read data
- pixel  out  12  sprite colour
- pixel_valid  out  1  pixel carries an opaque sprite pixel

## Operation
- Frame latch: on frame_start, capture sprite_x, sprite_y, and show into x_l, y_l, and show_l. Clear line_base to 0. Position changes mid-frame have no effect until the next frame_start.
- Hit test, computed with 11-bit sums (no wrap):
  - row_hit = show_l && row ≥ y_l && row < y_l+SPR_H
  - in_spr = row_hit && col ≥ x_l && col < x_l+SPR_W
- Address: when pix_en && in_spr, rom_addr ← line_base + (col − x_l), truncated to 15 bits. Otherwise rom_addr holds its value.
- Line advance: on line_end, if the last row seen had row_hit, line_base ← line_base + SPR_W. No multiplier is used.
- Clipping: a sprite running past column 639 or row 479 is clipped.
  - Addresses of off-screen pixels are never issued.
  - Because the per-line advance uses line_base, the next line still starts at the correct offset.
- Tag pipeline: a hit flag (pix_en && in_spr) is delayed ROM_LAT+1 cycles to meet rom_data.
  - The output stage registers pixel ← rom_data and pixel_valid ← the delayed hit flag.
  - When the flag is low, pixel ← 12'h000.
- Priority:
  - frame_start beats line_end and pix_en in the same cycle. The pixel sample in that cycle is dropped and line_base = 0.
  - line_end and pix_en together: the address is computed with the old line_base, then line_base advances.
- Reset (asynchronous, any time including mid-frame):
  - rom_addr=0, pixel=0, pixel_valid=0, line_base=0, show_l=0, x_l=0, y_l=0, and the tag pipeline is cleared.
  - No sprite output until the next frame_start.

## Timing
- A pix_en sample at cycle T gives rom_addr at T+1, rom_data at T+1+ROM_LAT, and pixel/pixel_valid at T+2+ROM_LAT. This is 3 cycles for ROM_LAT=1.
- Back-to-back pix_en (every clk) is supported at full rate. The pipeline never stalls.
- With pix_en low, pipeline tags still advance every clk, so pixel_valid is a single-cycle pulse per sampled pixel.
- frame_start and line_end are edge-free levels sampled for one cycle. Holding either high for multiple cycles repeats the action: latches reload, and line_base advances again.

## Configuration
- TRANSPARENT_KEY_EN defined: the output stage also requires rom_data ≠ KEY. Key-coloured sprite pixels give pixel_valid=0 and pixel=0, so the background shows through.
- TRANSPARENT_KEY_EN undefined: every in-sprite pixel is valid regardless of colour. KEY is unused.

## Test plan
- Reset then frame_start with sprite_x=100, sprite_y=50, show=1; pix_en at (100,50) → rom_addr=0 at T+1, pixel_valid=1 at T+3; (259,50) → addr 159; (260,50) → no valid.
- Row advance: after line_end on row 50, pixel (100,51) → rom_addr=160; (105,249) → rom_addr=199*160+5=31845; row 250 → no valid.
- Right clip: sprite_x=600, pixels 600..639 → addrs 0..39; after line_end, (600, y+1) → addr 160.
- sprite_x changed to 200 mid-frame → addresses still follow x=100 until the next frame_start; show=0 at frame_start → no pixel_valid all frame.
- Assert rst_n low mid-sprite → pixel_valid=0 and rom_addr=0 immediately. After release, no valid output until frame_start.
- With TRANSPARENT_KEY_EN and rom_data=12'hFFF at a hit → pixel_valid=0. Without the macro → pixel_valid=1, pixel=12'hFFF.
